// File: rtl/sr_jk_register_bank.sv
// sr_jk_register_bank: WIDTH-bit SR/JK/D/T register bank with parallel load and SR 1/1 error bookkeeping
module sr_jk_register_bank #(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter int SR11_POLICY = 0,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] illegal,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count
);
  logic [WIDTH-1:0] both, hold, p11, q_sr, q_jk, nxt;
  logic sr_upd, ill_evt;
  assign both = a & b;
  assign hold = ~a & ~b & q;
  // s=r=1 resolution: policy 3 forces 0 like reset-dominant, the flag comes from illegal
  assign p11 = SR11_POLICY == 0 ? q : SR11_POLICY == 1 ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
  assign q_sr = (a & ~b) | hold | (both & p11);
  assign q_jk = (a & ~b) | hold | (both & ~q);
  assign nxt = mode == 2'b00 ? q_sr : mode == 2'b01 ? q_jk : mode == 2'b10 ? a : q ^ a;
  assign sr_upd = !load && en && mode == 2'b00;
  assign ill_evt = sr_upd && |both;
  assign qbar = ~q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VAL;
      illegal <= '0;
      err_sticky <= 1'b0;
      err_count <= '0;
    end else begin
      q <= load ? load_data : en ? nxt : q;
      illegal <= sr_upd ? both : '0;
      if (ill_evt) begin
        err_sticky <= 1'b1;
        err_count <= err_clr ? CNT_W'(1) : &err_count ? err_count : err_count + CNT_W'(1);
      end else if (err_clr) begin
        err_sticky <= 1'b0;
        err_count <= '0;
      end
    end
  end
endmodule

// File: doc/sr_jk_register_bank.md
# sr_jk_register_bank

Parametrised bank of WIDTH edge-triggered storage bits, each behaving as an SR, JK, D or T flip-flop according to a run-time mode select. It generalises the single-bit SR flip-flop. It adds a parallel-load path, a clock enable, a configurable resolution for the SR 1/1 input, and error bookkeeping for that illegal input. It sits in the sequential-circuits library as the general-purpose state register for small controllers and counters.

## Interface
- WIDTH, 4: number of storage bits (1..32).
- RESET_VAL, {WIDTH{1'b0}}: value of q after reset.
- SR11_POLICY, 0: SR-mode response to s=r=1.
  - 0 = hold.
  - 1 = set-dominant.
  - 2 = reset-dominant.
  - 3 = force 0 and flag.
- CNT_W, 8: width of the error counter.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  clock enable for the mode-driven update.
- load  input  1  synchronous parallel load; has priority over en.
- load_data  input  WIDTH  value loaded when load=1.
- mode  input  2  per-cycle behaviour select: 00 SR, 01 JK, 10 D, 11 T.
- a  input  WIDTH  per-bit first input: S, J, D or T depending on mode.
- b  input  WIDTH  per-bit second input: R or K; ignored in D and T modes.
- err_clr  input  1  synchronous clear of err_sticky and err_count.
- q  output  WIDTH  registered state.
- qbar  output  WIDTH  combinational ~q.
- illegal  output  WIDTH  registered per-bit mask: bit i was driven s=r=1 in SR mode on the previous accepted update.
- err_sticky  output  1  set by any illegal event; held until err_clr or reset.
- err_count  output  CNT_W  count of cycles containing at least one illegal bit; saturates at all-ones.

## Operation
- Reset (rst_n=0, asynchronous): q=RESET_VAL, illegal=0, err_sticky=0, err_count=0. All outputs hold these values while rst_n=0. rst_n is released synchronously by the upstream reset synchroniser.
- Update priority at each rising edge: load > en > hold.
  - load=1: q<=load_data, illegal<=0. mode, a and b are ignored.
  - load=0, en=1: each bit i updates per mode (see list below).
  - load=0, en=0: q holds and illegal<=0.
- Per-bit update when load=0, en=1:
  - SR: 00 hold; 01 clear; 10 set; 11 resolved per SR11_POLICY. illegal[i]<=1 for 11 under every policy, else 0.
  - JK: 00 hold; 01 clear; 10 set; 11 toggle. illegal<=0.
  - D: q[i]<=a[i]; b ignored. illegal<=0.
  - T: q[i]<=q[i]^a[i]; b ignored. illegal<=0.
- An illegal event is a cycle with load=0, en=1, mode=00 and |(a&b)=1.
  - On an illegal event: err_sticky<=1 and err_count<=err_count+1, saturating at 2^CNT_W-1.
  - Multiple illegal bits in one cycle count once.
- err_clr=1 with no illegal event: err_sticky<=0, err_count<=0.
- err_clr=1 in the same cycle as an illegal event: the new event wins. err_sticky<=1, err_count<=1.
- Mode changes take effect on the same edge; there is no pipeline and no mode-change hazard.
- No X is ever produced on q. The SR 1/1 input is always resolved deterministically.

## Timing
- Latency is one cycle from sampled inputs to q, illegal, err_sticky and err_count.
- qbar is combinational from q and has zero additional latency.
- Every cycle is accepted. There is no backpressure and no handshake.
- Counter wrap is forbidden. At saturation err_count holds and err_sticky stays 1.
- Reset asserted mid-operation clears all state immediately, regardless of clk. The first edge after release performs a normal update.

## Test plan
- Reset and D mode (WIDTH=4, RESET_VAL=4'b1010):
  - Stimulus: rst_n=0, then release; mode=10, en=1, a=4'b0110.
  - Required: q=1010 and qbar=0101 during reset; q=0110 one edge after the update.
- SR policies (SR11_POLICY=0,1,2,3 in separate runs, q=4'b0101):
  - Stimulus: mode=00, a=4'b1111, b=4'b1111.
  - Required q: 0101 (hold), 1111 (set-dominant), 0000 (reset-dominant), 0000 (force 0).
  - Required in all runs: illegal=1111, err_sticky=1, err_count=1.
- JK and T toggles (q=4'b0011):
  - Stimulus: mode=01, a=b=4'b1111; then mode=11, a=4'b0101.
  - Required: q=1100, then q=1001; illegal stays 0 throughout.
- Priority (q=4'b0000):
  - Stimulus: load=1, load_data=4'b1001 with mode=00, a=b=1111, en=1.
  - Required: q=1001; illegal=0; err_count unchanged.
  - Stimulus: en=0, a=1111.
  - Required: q holds.
- Error bookkeeping (CNT_W=2):
  - Stimulus: five consecutive illegal cycles.
  - Required: err_count saturates at 3.
  - Stimulus: err_clr=1 together with an illegal cycle.
  - Required: err_count=1, err_sticky=1.
  - Stimulus: err_clr=1 alone.
  - Required: err_count=0, err_sticky=0.
- Asynchronous reset mid-stream:
  - Stimulus: in T mode with a=1111 toggling each cycle, drive rst_n low between clock edges.
  - Required: q=RESET_VAL and err_count=0 immediately, before the next edge.
